snake_core: RTL and testbench

Parametrised snake game engine for the VGA snake game. It holds the snake as a cell-coordinate shift register and advances it one cell per game tick, taking direction from the debounced buttons. It grows on a food-eaten pulse and detects wall and self collisions through a RUN/DEAD state machine. It also answers per-pixel "is head / is body" queries for the renderer with one cycle of latency.

---
 rtl/snake_pkg.sv | 37 +++
 rtl/snake_tick_gen.sv | 28 ++
 rtl/snake_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_snake_core.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg: shared types for the snake game engine.
// Coordinates are held in 10 bits, enough for any grid up to 1024 cells per side.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT,
    DIR_LEFT,
    DIR_UP,
    DIR_DOWN
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_t;

  localparam int COORD_W = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  // Direction that would reverse the snake onto its own neck.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_RIGHT: return DIR_LEFT;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_UP:    return DIR_DOWN;
      default:   return DIR_UP;
    endcase
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// snake_tick_gen: game-step timebase. Counts 0..TICK_DIV-1 while enabled and
// flags the last count; the counter wraps to 0 on that cycle.
module snake_tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = en && (count_reg == CW'(TICK_DIV - 1));

  // Free-running divider, held at zero whenever the game is not running.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? '0 : count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/snake_core.sv
// snake_core: snake game engine. Segment shift register, direction control,
// growth, wall/self collision and registered per-pixel head/body lookup.
// Build option: define SNAKE_WRAP_EN to make the playfield edges wrap around
// instead of killing the snake.
module snake_core
  import snake_pkg::*;
#(
  parameter int CELL_PX   = 10,
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 48,
  parameter int MAX_LEN   = 32,
  parameter int START_LEN = 3,
  parameter int START_X   = 20,
  parameter int START_Y   = 20,
  parameter int TICK_DIV  = 10_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         btn_up,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic                         btn_down,
  input  logic                         grow,
  input  logic [9:0]                   pixel_x,
  input  logic [9:0]                   pixel_y,
  output logic                         head_px,
  output logic                         body_px,
  output logic [$clog2(GRID_W)-1:0]    head_x,
  output logic [$clog2(GRID_H)-1:0]    head_y,
  output logic [$clog2(MAX_LEN+1)-1:0] length,
  output logic                         alive,
  output logic                         step,
  output logic                         died
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int PW = 16;

  localparam coord_t X_MAX = coord_t'(GRID_W - 1);
  localparam coord_t Y_MAX = coord_t'(GRID_H - 1);
  localparam logic [LW-1:0] START_LEN_L = LW'(START_LEN);
  localparam logic [LW-1:0] MAX_LEN_L   = LW'(MAX_LEN);
  localparam logic [MAX_LEN-1:0] BODY_MASK = ~MAX_LEN'(1);

  state_t state_reg, state_next;
  dir_t   dir_reg, dir_next, last_dir_reg;
  dir_t   req_dir, ref_dir;
  logic   req_valid;

  logic            grow_pending_reg;
  logic [LW-1:0]   length_reg;
  cell_t           seg_reg [MAX_LEN];
  cell_t           next_head;
  logic            wall_hit, self_hit, growing;
  logic            tick, do_move, do_die, do_init;
  logic            step_reg, died_reg, head_px_reg, body_px_reg;
  logic [MAX_LEN-1:0] hit, live;
  logic            body_any;

  snake_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_reg == ST_RUN),
    .clr   (state_reg != ST_RUN),
    .tick  (tick)
  );

  // Candidate head position one cell ahead, plus edge-of-field detection.
  always_comb begin
    next_head = seg_reg[0];
    wall_hit  = 1'b0;
    case (dir_reg)
      DIR_RIGHT: begin
        if (seg_reg[0].x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
          next_head.x = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_head.x = seg_reg[0].x + coord_t'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_reg[0].x == '0) begin
`ifdef SNAKE_WRAP_EN
          next_head.x = X_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_head.x = seg_reg[0].x - coord_t'(1);
        end
      end
      DIR_UP: begin
        if (seg_reg[0].y == '0) begin
`ifdef SNAKE_WRAP_EN
          next_head.y = Y_MAX;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_head.y = seg_reg[0].y - coord_t'(1);
        end
      end
      default: begin
        if (seg_reg[0].y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
          next_head.y = '0;
`else
          wall_hit = 1'b1;
`endif
        end else begin
          next_head.y = seg_reg[0].y + coord_t'(1);
        end
      end
    endcase
  end

  // Self collision: the tail cell is vacated by the move unless the snake grows.
  always_comb begin
    growing  = grow_pending_reg && (length_reg < MAX_LEN_L);
    self_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((seg_reg[i] == next_head) &&
          (LW'(i) < (growing ? length_reg : length_reg - LW'(1)))) begin
        self_hit = 1'b1;
      end
    end
  end

  // Game state machine: decides whether this cycle moves, dies or re-initialises.
  always_comb begin
    state_next = state_reg;
    do_move    = 1'b0;
    do_die     = 1'b0;
    do_init    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          do_init    = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          if (wall_hit || self_hit) begin
            state_next = ST_DEAD;
            do_die     = 1'b1;
          end else begin
            do_move = 1'b1;
          end
        end
      end
      ST_DEAD: begin
        if (start) begin
          state_next = ST_RUN;
          do_init    = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Button arbitration; reversal is judged against the move being executed
  // this cycle so two quick presses cannot turn the snake back on itself.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = DIR_RIGHT;
    if (btn_up)         req_dir = DIR_UP;
    else if (btn_left)  req_dir = DIR_LEFT;
    else if (btn_right) req_dir = DIR_RIGHT;
    else if (btn_down)  req_dir = DIR_DOWN;
    else                req_valid = 1'b0;
    ref_dir  = do_move ? dir_reg : last_dir_reg;
    dir_next = dir_reg;
    if ((state_reg == ST_RUN) && req_valid && (req_dir != opposite(ref_dir))) begin
      dir_next = req_dir;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Direction, growth bookkeeping, length and event strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_reg          <= DIR_RIGHT;
      last_dir_reg     <= DIR_RIGHT;
      grow_pending_reg <= 1'b0;
      length_reg       <= START_LEN_L;
      step_reg         <= 1'b0;
      died_reg         <= 1'b0;
    end else begin
      step_reg <= do_move;
      died_reg <= do_die;
      if (do_init) begin
        dir_reg          <= DIR_RIGHT;
        last_dir_reg     <= DIR_RIGHT;
        grow_pending_reg <= 1'b0;
        length_reg       <= START_LEN_L;
      end else begin
        dir_reg <= dir_next;
        if (do_move) begin
          last_dir_reg <= dir_reg;
          if (growing) length_reg <= length_reg + LW'(1);
        end
        // A grow arriving on a step cycle is kept for the following step.
        if ((state_reg == ST_RUN) && grow) grow_pending_reg <= 1'b1;
        else if (do_move)                  grow_pending_reg <= 1'b0;
      end
    end
  end

  // Segment shift register; on growth the old tail is copied one slot further.
  always_ff @(posedge clk) begin
    if (reset || do_init) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_reg[k] <= '{x: coord_t'(START_X - k), y: coord_t'(START_Y)};
      end
    end else if (do_move) begin
      seg_reg[0] <= next_head;
      for (int k = 1; k < MAX_LEN; k++) begin
        seg_reg[k] <= seg_reg[k-1];
      end
    end
  end

  // Per-segment pixel hit test against the full inclusive cell rectangle.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_pix
    logic [PW-1:0] x_lo, y_lo;
    assign x_lo    = PW'(seg_reg[gi].x) * PW'(CELL_PX);
    assign y_lo    = PW'(seg_reg[gi].y) * PW'(CELL_PX);
    assign hit[gi] = (PW'(pixel_x) >= x_lo) && (PW'(pixel_x) <= x_lo + PW'(CELL_PX - 1)) &&
                     (PW'(pixel_y) >= y_lo) && (PW'(pixel_y) <= y_lo + PW'(CELL_PX - 1));
    assign live[gi] = (LW'(gi) < length_reg);
  end

  assign body_any = |(hit & live & BODY_MASK);

  // Renderer lookup results, one cycle behind the raster position.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_px_reg <= 1'b0;
      body_px_reg <= 1'b0;
    end else begin
      head_px_reg <= hit[0];
      body_px_reg <= body_any;
    end
  end

  assign head_px = head_px_reg;
  assign body_px = body_px_reg;
  assign head_x  = seg_reg[0].x[XW-1:0];
  assign head_y  = seg_reg[0].y[YW-1:0];
  assign length  = length_reg;
  assign alive   = (state_reg == ST_RUN);
  assign step    = step_reg;
  assign died    = died_reg;

endmodule

// File: tb/tb_snake_core.sv
// tb_snake_core: randomized and directed stimulus for snake_core with a
// queue-based snake model; a monitor pops expected moves/deaths and pixel
// lookups and compares them with the DUT outputs.
module tb_snake_core;

  localparam int CP = 10;
  localparam int GW = 64;
  localparam int GH = 48;
  localparam int ML = 8;
  localparam int SL = 3;
  localparam int SX = 20;
  localparam int SY = 20;
  localparam int TD = 4;

  logic       clk, reset, start, grow;
  logic       btn_up, btn_left, btn_right, btn_down;
  logic [9:0] pixel_x, pixel_y;
  logic       head_px, body_px, alive, step, died;
  logic [5:0] head_x, head_y;
  logic [3:0] length;

  snake_core #(
    .CELL_PX(CP), .GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .START_LEN(SL),
    .START_X(SX), .START_Y(SY), .TICK_DIV(TD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down),
    .grow(grow), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .head_px(head_px), .body_px(body_px), .head_x(head_x), .head_y(head_y),
    .length(length), .alive(alive), .step(step), .died(died)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { int x; int y; } pt_t;
  typedef struct packed { bit died; int hx; int hy; int len; } txn_t;
  typedef struct packed { bit h; bit b; } pix_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the snake is a queue of live cells, head first.
  pt_t  m_snake[$];
  int   m_state = 0;   // 0 idle, 1 run, 2 dead
  int   m_dir = 0;     // 0 right, 1 left, 2 up, 3 down (opposite = d^1)
  int   m_last = 0;
  bit   m_pend = 0;
  int   m_cnt = 0;
  int   m_events = 0;
  txn_t exp_q[$];
  pix_t pix_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void m_init();
    m_snake.delete();
    for (int k = 0; k < SL; k++) m_snake.push_back('{x: SX - k, y: SY});
    m_dir = 0; m_last = 0; m_pend = 0; m_cnt = 0;
  endfunction

  function automatic void m_step();
    pt_t nh = m_snake[0];
    bit  dead = 0;
    bit  growing;
    int  lim;
    case (m_dir)
      0: nh.x = nh.x + 1;
      1: nh.x = nh.x - 1;
      2: nh.y = nh.y - 1;
      default: nh.y = nh.y + 1;
    endcase
`ifdef SNAKE_WRAP_EN
    nh.x = (nh.x + GW) % GW;
    nh.y = (nh.y + GH) % GH;
`else
    if (nh.x < 0 || nh.x >= GW || nh.y < 0 || nh.y >= GH) dead = 1;
`endif
    growing = m_pend && (m_snake.size() < ML);
    lim = growing ? m_snake.size() - 1 : m_snake.size() - 2;
    for (int i = 1; i <= lim; i++) if (m_snake[i] == nh) dead = 1;
    m_events++;
    if (dead) begin
      m_state = 2;
      exp_q.push_back('{died: 1'b1, hx: m_snake[0].x, hy: m_snake[0].y, len: m_snake.size()});
    end else begin
      m_snake.push_front(nh);
      if (!growing) void'(m_snake.pop_back());
      m_last = m_dir;
      exp_q.push_back('{died: 1'b0, hx: nh.x, hy: nh.y, len: m_snake.size()});
    end
  endfunction

  function automatic void m_cycle();
    bit stepped = 0;
    int req = -1;
    if (m_cnt == TD - 1) begin
      stepped = 1;
      m_cnt = 0;
      m_step();
    end else begin
      m_cnt++;
    end
    if (m_state == 1) begin
      if (btn_up) req = 2;
      else if (btn_left) req = 1;
      else if (btn_right) req = 0;
      else if (btn_down) req = 3;
      if (req >= 0 && req != (m_last ^ 1)) m_dir = req;
    end
    if (stepped) m_pend = 0;
    if (grow) m_pend = 1;
  endfunction

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_init();
      m_state = 0;
    end else if (m_state == 1) begin
      m_cycle();
    end else if (start) begin
      m_init();
      m_state = 1;
    end
  end

  function automatic pix_t pix_exp(input int px, input int py);
    pix_t r = '0;
    for (int i = 0; i < m_snake.size(); i++) begin
      if (px >= m_snake[i].x * CP && px <= m_snake[i].x * CP + CP - 1 &&
          py >= m_snake[i].y * CP && py <= m_snake[i].y * CP + CP - 1) begin
        if (i == 0) r.h = 1'b1;
        else        r.b = 1'b1;
      end
    end
    return r;
  endfunction

  // Monitor: compares against expectations produced by the model.
  initial forever begin
    txn_t t;
    pix_t p;
    @(negedge clk);
    chk("alive", int'(alive), int'(m_state == 1));
    if (step || died) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_event: got step=%0d died=%0d expected none at %0t", step, died, $time);
      end else begin
        t = exp_q.pop_front();
        chk("txn_died", int'(died), int'(t.died));
        chk("txn_step", int'(step), int'(!t.died));
        chk("txn_head_x", int'(head_x), t.hx);
        chk("txn_head_y", int'(head_y), t.hy);
        chk("txn_length", int'(length), t.len);
        $display("txn %s head=(%0d,%0d) len=%0d at %0t", t.died ? "died" : "step", t.hx, t.hy, t.len, $time);
      end
    end else if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL missing_event: got none expected died=%0d head=(%0d,%0d) at %0t", t.died, t.hx, t.hy, $time);
    end
    if (pix_q.size() > 0) begin
      p = pix_q.pop_front();
      chk("head_px", int'(head_px), int'(p.h));
      chk("body_px", int'(body_px), int'(p.b));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pix(input int px, input int py);
    pixel_x = 10'(px);
    pixel_y = 10'(py);
    pix_q.push_back(reset ? pix_t'(0) : pix_exp(px, py));
  endtask

  task automatic query(input int px, input int py);
    set_pix(px, py);
    cyc();
  endtask

  task automatic wait_events(input int n);
    int target = m_events + n;
    int budget = n * TD * 3 + 20;
    while (m_events < target && budget > 0) begin
      cyc();
      budget--;
    end
    if (m_events < target) begin
      checks++; errors++;
      $display("FAIL wait_events: got %0d events expected %0d", m_events, target);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pulse_grow();
    grow = 1'b1; cyc(); grow = 1'b0;
  endtask

  task automatic do_reset();
    {btn_up, btn_left, btn_right, btn_down} = 4'b0;
    start = 1'b0; grow = 1'b0; reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  initial begin
    int bx, by, cx, cy, idx;
    reset = 1'b1; start = 1'b0; grow = 1'b0;
    {btn_up, btn_left, btn_right, btn_down} = 4'b0;
    pixel_x = '0; pixel_y = '0;
    cyc(); cyc(); cyc();
    chk("rst_head_x", int'(head_x), SX);
    chk("rst_head_y", int'(head_y), SY);
    chk("rst_length", int'(length), SL);
    chk("rst_alive", int'(alive), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_died", int'(died), 0);
    chk("rst_head_px", int'(head_px), 0);
    chk("rst_body_px", int'(body_px), 0);
    reset = 1'b0;

    // Pixel boundaries around the initial head cell (20,20).
    query(200, 200); query(209, 209); query(210, 200); query(199, 200);
    query(190, 205); query(180, 200); query(170, 200); query(200, 210);
    cyc();

    // Plain run to the right.
    pulse_start();
    wait_events(3);
    chk("a_head_x", int'(head_x), SX + 3);
    chk("a_head_y", int'(head_y), SY);
    chk("a_length", int'(length), SL);

    // Reversal is ignored; up then left turns up and then left.
    btn_left = 1'b1;
    wait_events(2);
    btn_left = 1'b0;
    chk("b_rev_head_x", int'(head_x), SX + 5);
    bx = m_snake[0].x; by = m_snake[0].y;
    btn_up = 1'b1; cyc(); btn_up = 1'b0; btn_left = 1'b1;
    wait_events(1);
    chk("b_up_head_x", int'(head_x), bx);
    chk("b_up_head_y", int'(head_y), by - 1);
    wait_events(1);
    btn_left = 1'b0;
    chk("b_left_head_x", int'(head_x), bx - 1);
    chk("b_left_head_y", int'(head_y), by - 1);

    // Growth, one segment per pulse, saturating at the maximum.
    do_reset();
    pulse_start();
    pulse_grow();
    wait_events(1);
    chk("c_len_grow", int'(length), SL + 1);
    wait_events(1);
    chk("c_len_hold", int'(length), SL + 1);
    for (int g = 0; g < ML - SL - 1; g++) begin
      pulse_grow();
      wait_events(1);
    end
    chk("c_len_max", int'(length), ML);
    pulse_grow();
    wait_events(1);
    chk("c_len_sat", int'(length), ML);

    // Length 5 curling up, left, down into its own body; then restart.
    do_reset();
    pulse_start();
    pulse_grow(); wait_events(1);
    pulse_grow(); wait_events(1);
    chk("d_len5", int'(length), 5);
    btn_up = 1'b1;   wait_events(1); btn_up = 1'b0;
    btn_left = 1'b1; wait_events(1); btn_left = 1'b0;
    btn_down = 1'b1; wait_events(1); btn_down = 1'b0;
    chk("d_dead_alive", int'(alive), 0);
    chk("d_dead_len", int'(length), 5);
    pulse_start();
    chk("d_restart_x", int'(head_x), SX);
    chk("d_restart_y", int'(head_y), SY);
    chk("d_restart_len", int'(length), SL);
    chk("d_restart_alive", int'(alive), 1);

    // Right wall.
    do_reset();
    pulse_start();
    wait_events(GW - 1 - SX);
    chk("e_edge_x", int'(head_x), GW - 1);
    wait_events(1);
`ifdef SNAKE_WRAP_EN
    chk("e_wrap_x", int'(head_x), 0);
    chk("e_wrap_alive", int'(alive), 1);
`else
    chk("e_wall_x", int'(head_x), GW - 1);
    chk("e_wall_alive", int'(alive), 0);
`endif

    // Top wall.
    do_reset();
    pulse_start();
    btn_up = 1'b1;
    wait_events(SY + 1);
    btn_up = 1'b0;
`ifdef SNAKE_WRAP_EN
    chk("e_top_wrap_y", int'(head_y), GH - 1);
`else
    chk("e_top_y", int'(head_y), 0);
    chk("e_top_alive", int'(alive), 0);
`endif

    // Reset beats a simultaneous start.
    reset = 1'b1; start = 1'b1; cyc();
    reset = 1'b0; start = 1'b0; cyc();
    chk("f_reset_wins", int'(alive), 0);

    // Randomized play with random raster probes near the snake.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) {btn_up, btn_left, btn_right, btn_down} = 4'($urandom);
      grow  = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 799) == 0);
      idx = $urandom_range(0, m_snake.size() - 1);
      cx = m_snake[idx].x + $urandom_range(0, 2) - 1;
      cy = m_snake[idx].y + $urandom_range(0, 2) - 1;
      if (cx < 0) cx = 0;
      if (cx > GW - 1) cx = GW - 1;
      if (cy < 0) cy = 0;
      if (cy > GH - 1) cy = GH - 1;
      set_pix(cx * CP + $urandom_range(0, CP - 1), cy * CP + $urandom_range(0, CP - 1));
      cyc();
    end
    {btn_up, btn_left, btn_right, btn_down} = 4'b0;
    grow = 1'b0; start = 1'b0; reset = 1'b0;
    cyc(); cyc(); cyc();
    chk("drain_events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
